// File: rtl/gDefine.sv
// gDefine: shared datapath types for the vector core, including the writeback entry.
// Contents:
//   LANES / WORD_W       vector geometry (Vector_t = LANES x WORD_W bits)
//   VREG_W / GREG_W      register index widths
//   RID_W                reservation/warp ID width
//   WbEntry_t            packed {vreg, rid, data}; the unit the writeback arbiter moves
package gDefine;
    localparam int LANES  = 4;
    localparam int WORD_W = 32;
    localparam int VEC_W  = LANES * WORD_W;
    localparam int VREG_W = 5;
    localparam int GREG_W = 5;
    localparam int RID_W  = 4;
    typedef logic [VEC_W-1:0]  Vector_t;
    typedef logic [VREG_W-1:0] VRegIdx_t;
    typedef logic [GREG_W-1:0] GRegIdx_t;
    typedef logic [RID_W-1:0]  RsvID_t;
    typedef struct packed {
        VRegIdx_t vreg;
        RsvID_t   rid;
        Vector_t  data;
    } WbEntry_t;
    localparam int WB_ENTRY_W = $bits(WbEntry_t);
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic in-order FIFO with occupancy count and guarded push/pop.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (pointers/count only)
//   i_push, i_data       write request and data; ignored while full
//   o_full               count == DEPTH
//   i_pop                read request; ignored while empty
//   o_data               entry at the read pointer (combinational from storage)
//   o_empty              count == 0
//   o_count              entries held
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = r_count == CNT_W'(DEPTH);
    assign o_empty   = r_count == '0;
    // Full refuses a push even when a pop frees a slot in the same cycle,
    // so the ready signal never depends on the consumer.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk)
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
endmodule

// File: rtl/wb_req_queue.sv
// wb_req_queue: per-channel writeback request queue feeding the register-file write arbiter.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   inValid/inVRegIdx/inData/inRID   result from the execution unit
//   inReady                          queue not full; push = inValid & inReady
//   wbReq                            head entry valid (arbiter request bit)
//   wbVRegIdx/wbData/wbRID           head entry payload
//   wbStall                          arbiter stall for this channel; head retires when low
//   occupancy                        entries held
//   stallCycles                      saturating count of cycles with wbReq & wbStall
module wb_req_queue
    import gDefine::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [VREG_W-1:0] inVRegIdx,
    input  logic [VEC_W-1:0]  inData,
    input  logic [RID_W-1:0]  inRID,
    output logic              inReady,
    output logic              wbReq,
    output logic [VREG_W-1:0] wbVRegIdx,
    output logic [VEC_W-1:0]  wbData,
    output logic [RID_W-1:0]  wbRID,
    input  logic              wbStall,
    output logic [CNT_W-1:0]  occupancy,
    output logic [15:0]       stallCycles
);
    WbEntry_t    w_in_entry;
    WbEntry_t    w_head;
    logic        w_full;
    logic        w_empty;
    logic [15:0] r_stall_cnt;

    assign w_in_entry = '{vreg: inVRegIdx, rid: inRID, data: inData};

    // wbReq and inReady come straight from the registered count, so neither
    // has a combinational path from wbStall or inValid.
    sync_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (inValid),
        .i_data  (w_in_entry),
        .o_full  (w_full),
        .i_pop   (~wbStall),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (occupancy)
    );

    assign inReady     = ~w_full;
    assign wbReq       = ~w_empty;
    assign wbVRegIdx   = w_head.vreg;
    assign wbRID       = w_head.rid;
    assign wbData      = w_head.data;
    assign stallCycles = r_stall_cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_stall_cnt <= '0;
        else if (~w_empty && wbStall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
endmodule

// File: doc/wb_req_queue.md
Name: wb_req_queue

Overview:
- Requester-side endpoint of the writeback arbitration interface.
- One instance sits at the tail of each execution channel. It buffers completed results (vreg index, data vector, reservation ID) in a small in-order FIFO.
- It presents the oldest entry to the writeback arbiter as one request channel, and retires that entry only in a cycle where the arbiter does not stall the channel.
- Together these give back-pressure from the single register-file write port to the execution pipeline.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- inValid  in  1  execution unit presents a result this cycle.
- inVRegIdx  in  VRegIdx_t  destination vector register.
- inData  in  Vector_t  result vector.
- inRID  in  RsvID_t  reservation/warp ID of result.
- inReady  out  1  queue can accept; push = inValid & inReady.
- wbReq  out  1  head entry valid; drives one bit of the arbiter request vector.
- wbVRegIdx  out  VRegIdx_t  head entry vreg.
- wbData  out  Vector_t  head entry data.
- wbRID  out  RsvID_t  head entry RID.
- wbStall  in  1  the arbiter's stall bit for this channel.
- occupancy  out  CNT_W  entries held.
- stallCycles  out  16  saturating count of cycles with wbReq & wbStall.

Behaviour:
- Reset (async assert, sync deassert by the environment): read/write pointers = 0, occupancy = 0, stallCycles = 0. Consequently wbReq = 0 and inReady = 1. Entry storage is not reset; wb payload outputs are don't-care while wbReq = 0.
- Storage: DEPTH-entry register array. Write pointer and read pointer are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Push: when inValid & inReady, write the entry at the write pointer and increment the pointer.
- Pop: when wbReq & !wbStall, increment the read pointer. The arbiter consumes the head combinationally in that same cycle.
- wbReq = (occupancy != 0). It must be purely registered, with no combinational path from wbStall or inValid.
- wb payload outputs = the entry at the read pointer, driven combinationally from registered state.
- inReady = (occupancy != DEPTH). It does not depend on wbStall, so there is no combinational loop through the arbiter. When full, a push is refused even if a pop occurs the same cycle.
- Simultaneous push and pop (occupancy between 1 and DEPTH-1): both pointers advance and occupancy is unchanged.
- Empty queue: a push cannot bypass to the output. Push-to-wbReq latency is exactly 1 cycle.
- Empty with wbStall = 1: ignored. The arbiter drives stall = 0 when it has no requests, so this case does not arise from it.
- Ordering: strict FIFO. Entries retire in push order, whatever the RID.
- inValid while inReady = 0: the entry is not captured. The producer must hold it (valid/ready rule). The payload must stay stable while inValid & !inReady.
- stallCycles: increments when wbReq & wbStall, saturates at 16'hFFFF, and clears only on reset.
- Reset mid-operation: all entries are discarded immediately. wbReq drops asynchronously with rst.
- Assertions in the bench:
  - no pop when empty;
  - no push when full;
  - occupancy equals write pointer minus read pointer, modulo DEPTH, with the full case disambiguated.

Decomposition:
- Vector_t, VRegIdx_t, RsvID_t and GRegIdx_t stay in the shared gDefine package.
- Add a packed WbEntry_t struct {VRegIdx_t vreg; RsvID_t rid; Vector_t data} there, so that the arbiter can later take WbEntry_t arrays.
- One natural sub-module: sync_fifo (generic width/depth FIFO with count). wb_req_queue wraps it with the wb handshake mapping and the stall counter.

Test Plan:
- Reset, then push one entry {vreg=5, rid=2, data=0xA5..} with wbStall = 0 -> wbReq = 1 on the next cycle with matching payload; popped that cycle; wbReq = 0 after; occupancy returns to 0.
- Hold wbStall = 1 and push 4 entries -> occupancy = 4, inReady = 0, 5th inValid not captured. Hold stall 10 cycles -> stallCycles = 10 (counting starts the cycle after the first push).
- Release wbStall with DEPTH = 4 full -> 4 pops on consecutive cycles in push order (rids 0, 1, 2, 3); inReady = 1 the cycle after the first pop.
- Continuous push every cycle with wbStall = 0 -> occupancy steady at 1, one retire per cycle; pointer wrap over 20 entries preserves order and data.
- Full queue, inValid = 1 and wbStall = 0 same cycle -> pop occurs, push refused, occupancy = 3; the entry is captured on the next cycle.
- Assert rst mid-burst with occupancy = 3 -> wbReq = 0, occupancy = 0, stallCycles = 0 without waiting for a clock edge; the first post-reset push reappears with a 1-cycle latency.
